// File: rtl/dds_pkg.sv
// Shared types and helpers for the polyphonic DDS.
// No logic; no latency.
// No flow control.
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MIX_SAT = 0;
    localparam int MIX_AVG = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int dw, input int voices);
        return dw + clog2(voices);
    endfunction

endpackage

// File: rtl/dds_phase_map.sv
// Maps an accumulator phase onto a quarter-wave ROM address plus output sign.
// Latency: combinational.
// No flow control.
module dds_phase_map #(
    parameter int PHASE_W = 22,
    parameter int ROM_AW  = 10
) (
    input  logic [PHASE_W-1:0] phase,
    output logic [ROM_AW-1:0]  rom_addr,
    output logic               sign
);

    logic              mirror;
    logic [ROM_AW-1:0] a;

    assign sign     = phase[PHASE_W-1];
    assign mirror   = phase[PHASE_W-2];
    assign a        = phase[PHASE_W-3 -: ROM_AW];
    assign rom_addr = mirror ? ~a : a;

    // Fractional phase below ROM resolution is deliberately discarded.
    if (PHASE_W > ROM_AW + 2) begin : g_frac
        logic frac_unused;
        assign frac_unused = ^phase[PHASE_W-3-ROM_AW:0];
    end

endmodule

// File: rtl/sine_rom.sv
// Quarter-wave sine magnitude table, 2^AW entries, non-negative, full scale 2^(DW-1)-1.
// Latency: one cycle registered read.
// No flow control; a new address may be presented every cycle.
module sine_rom #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    // Parabolic fit of sin over the first quadrant, sampled at bin centres.
    function automatic logic [DW-1:0] quarter_sine(input logic [AW-1:0] a);
        logic [63:0] x;
        logic [63:0] prod;
        x    = {{(64-AW){1'b0}}, a} * 64'd2 + 64'd1;
        prod = x * ((64'd1 << (AW + 2)) - x) * ((64'd1 << (DW - 1)) - 64'd1);
        return DW'(prod >> (2 * AW + 2));
    endfunction

    always_ff @(posedge clk) begin
        data <= quarter_sine(addr);
    end

endmodule

// File: rtl/dds_poly.sv
// Polyphonic DDS: VOICES phase accumulators sharing one sine ROM, mixed into one sample.
// Latency: new_sample_ready VOICES+2 cycles after the accepting edge.
// No backpressure; pulses arriving mid-sweep are dropped and flagged in sticky overrun.
module dds_poly
    import dds_pkg::*;
#(
    parameter int VOICES   = 4,
    parameter int PHASE_W  = 22,
    parameter int ROM_AW   = 10,
    parameter int DW       = 16,
    parameter int MIX_MODE = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sampling_pulse,
    input  logic [VOICES*PHASE_W-1:0] k,
    input  logic [VOICES-1:0]         voice_en,
    input  logic [VOICES-1:0]         phase_clr,
    output logic [DW-1:0]             sample,
    output logic                      new_sample_ready,
    output logic                      busy,
    output logic                      overrun
);

    localparam int SH    = clog2(VOICES);
    localparam int ACC_W = acc_width(DW, VOICES);
    localparam int IDX_W = (SH > 0) ? SH : 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (DW - 1)));

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          idx;
    logic [PHASE_W-1:0]        phase [VOICES];
    logic                      accept;
    logic [ROM_AW-1:0]         rom_addr;
    logic                      sign;
    logic [DW-1:0]             rom_data;
    logic                      s_d, en_d;
    logic signed [ACC_W-1:0]   acc, mag, value;
    logic                      acc_en;
    logic [DW-1:0]             mix;

    assign accept = (state == IDLE) && sampling_pulse;
    assign acc_en = ((state == SCAN) && (idx != '0)) || (state == DRAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (sampling_pulse) state_nxt = SCAN;
            SCAN:    if (idx == IDX_W'(VOICES - 1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if ((state == SCAN) && (idx != IDX_W'(VOICES - 1))) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Retrigger wins over advance; disabled voices freeze their phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < VOICES; i++) phase[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < VOICES; i++) begin
                if (phase_clr[i])     phase[i] <= '0;
                else if (voice_en[i]) phase[i] <= phase[i] + k[i*PHASE_W +: PHASE_W];
            end
        end
    end

    dds_phase_map #(
        .PHASE_W (PHASE_W),
        .ROM_AW  (ROM_AW)
    ) u_map (
        .phase    (phase[idx]),
        .rom_addr (rom_addr),
        .sign     (sign)
    );

    sine_rom #(
        .AW (ROM_AW),
        .DW (DW)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // Sign and enable travel one cycle behind the address to line up with ROM data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_d  <= 1'b0;
            en_d <= 1'b0;
        end else begin
            s_d  <= sign;
            en_d <= voice_en[idx];
        end
    end

    assign mag   = ACC_W'(rom_data);
    assign value = !en_d ? '0 : (s_d ? -mag : mag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       acc <= '0;
        else if (accept) acc <= '0;
        else if (acc_en) acc <= acc + value;
    end

    always_comb begin
        mix = DW'(acc);
        if (MIX_MODE == MIX_AVG)  mix = DW'(acc >>> SH);
        else if (acc > SAT_HI)    mix = SAT_HI[DW-1:0];
        else if (acc < SAT_LO)    mix = SAT_LO[DW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample           <= '0;
            new_sample_ready <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            new_sample_ready <= (state == DONE);
            if (state == DONE) sample <= mix;
            if (sampling_pulse && (state != IDLE)) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dds_poly.sv
// Self-checking bench for dds_poly: saturating and averaging instances share stimulus.
// Reference model tracks phases and computes the mix arithmetically from quadrant rules.
module tb_dds_poly;

    localparam int VOICES  = 4;
    localparam int PHASE_W = 22;
    localparam int ROM_AW  = 10;
    localparam int DW      = 16;

    logic                      clk;
    logic                      reset;
    logic                      sampling_pulse;
    logic [VOICES*PHASE_W-1:0] k;
    logic [VOICES-1:0]         voice_en;
    logic [VOICES-1:0]         phase_clr;
    logic [DW-1:0]             sample_sat, sample_avg;
    logic                      rdy_sat, rdy_avg, busy_sat, busy_avg, ovr_sat, ovr_avg;

    int checks   = 0;
    int failures = 0;
    int ref_phase [VOICES];
    int lat, bcnt, rcnt;
    logic [DW-1:0] exp_sat, exp_avg;

    dds_poly #(.VOICES(VOICES), .PHASE_W(PHASE_W), .ROM_AW(ROM_AW), .DW(DW), .MIX_MODE(0)) dut_sat (
        .clk(clk), .reset(reset), .sampling_pulse(sampling_pulse), .k(k),
        .voice_en(voice_en), .phase_clr(phase_clr), .sample(sample_sat),
        .new_sample_ready(rdy_sat), .busy(busy_sat), .overrun(ovr_sat)
    );

    dds_poly #(.VOICES(VOICES), .PHASE_W(PHASE_W), .ROM_AW(ROM_AW), .DW(DW), .MIX_MODE(1)) dut_avg (
        .clk(clk), .reset(reset), .sampling_pulse(sampling_pulse), .k(k),
        .voice_en(voice_en), .phase_clr(phase_clr), .sample(sample_avg),
        .new_sample_ready(rdy_avg), .busy(busy_avg), .overrun(ovr_avg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Table value: floor(32767 * t*(2-t)) with t = (a+0.5)/1024.
    function automatic int rom_ref(input int a);
        longint t;
        t = 2 * a + 1;
        return int'((longint'(32767) * t * (longint'(4096) - t)) / longint'(4194304));
    endfunction

    function automatic int voice_value(input int ph);
        int quad, off, v;
        quad = ph / (1 << 20);
        off  = (ph / (1 << 10)) % 1024;
        v    = rom_ref((quad % 2 == 1) ? 1023 - off : off);
        return (quad >= 2) ? -v : v;
    endfunction

    function automatic int model_mix(input int mode);
        int acc;
        acc = 0;
        for (int i = 0; i < VOICES; i++)
            if (voice_en[i]) acc += voice_value(ref_phase[i]);
        if (mode == 1) return acc >>> 2;
        if (acc > 32767) return 32767;
        if (acc < -32768) return -32768;
        return acc;
    endfunction

    task automatic set_k(input int i, input int kv);
        k[i*PHASE_W +: PHASE_W] = PHASE_W'(kv);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sampling_pulse = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < VOICES; i++) ref_phase[i] = 0;
    endtask

    // Issues one accepted pulse and waits (bounded) for the ready strobe.
    task automatic run_pulse(output int l, output int b);
        for (int i = 0; i < VOICES; i++) begin
            if (phase_clr[i])     ref_phase[i] = 0;
            else if (voice_en[i]) ref_phase[i] = (ref_phase[i] + int'(k[i*PHASE_W +: PHASE_W])) % (1 << 22);
        end
        sampling_pulse = 1'b1;
        @(posedge clk); #1;
        sampling_pulse = 1'b0;
        l = -1;
        b = 0;
        for (int c = 0; c < 16; c++) begin
            if (busy_sat) b++;
            if (rdy_sat) begin
                l = c;
                break;
            end
            @(posedge clk); #1;
        end
        exp_sat = DW'(model_mix(0));
        exp_avg = DW'(model_mix(1));
    endtask

    task automatic test_reset();
        reset = 1'b0; sampling_pulse = 1'b0; k = '0; voice_en = '0; phase_clr = '0;
        #2 reset = 1'b1;
        #2;
        checks++;
        if ({sample_sat, rdy_sat, busy_sat, ovr_sat} !== 19'd0) begin
            failures++; $display("FAIL reset_sat: got %h want 0", {sample_sat, rdy_sat, busy_sat, ovr_sat});
        end
        checks++;
        if ({sample_avg, rdy_avg, busy_avg, ovr_avg} !== 19'd0) begin
            failures++; $display("FAIL reset_avg: got %h want 0", {sample_avg, rdy_avg, busy_avg, ovr_avg});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < VOICES; i++) ref_phase[i] = 0;
        voice_en = 4'b0001; set_k(0, 22'h100000);
        sampling_pulse = 1'b1;
        @(posedge clk); #1;
        sampling_pulse = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy_sat !== 1'b1) begin
            failures++; $display("FAIL reset_midscan_busy: got %b want 1", busy_sat);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({sample_sat, rdy_sat, busy_sat, ovr_sat} !== 19'd0) begin
            failures++; $display("FAIL reset_midscan: got %h want 0", {sample_sat, rdy_sat, busy_sat, ovr_sat});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_pulse(lat, bcnt);
        checks++;
        if (lat != 6) begin failures++; $display("FAIL reset_after_latency: got %0d want 6", lat); end
        checks++;
        if (sample_sat !== exp_sat) begin
            failures++; $display("FAIL reset_after_sample: got %h want %h", sample_sat, exp_sat);
        end
    endtask

    task automatic test_single_voice();
        do_reset();
        voice_en = 4'b0001; phase_clr = '0; k = '0; set_k(0, 22'h100000);
        run_pulse(lat, bcnt);
        checks++;
        if (lat != 6) begin failures++; $display("FAIL single_latency: got %0d want 6", lat); end
        checks++;
        if (bcnt != 6) begin failures++; $display("FAIL single_busy_cycles: got %0d want 6", bcnt); end
        checks++;
        if (sample_sat !== DW'(rom_ref(1023))) begin
            failures++; $display("FAIL single_sample_sat: got %h want %h", sample_sat, DW'(rom_ref(1023)));
        end
        checks++;
        if (sample_avg !== exp_avg) begin
            failures++; $display("FAIL single_sample_avg: got %h want %h", sample_avg, exp_avg);
        end
        @(posedge clk); #1;
        checks++;
        if (rdy_sat !== 1'b0 || busy_sat !== 1'b0) begin
            failures++; $display("FAIL single_strobe_width: got rdy=%b busy=%b want 0 0", rdy_sat, busy_sat);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sample_sat !== exp_sat) begin
            failures++; $display("FAIL single_hold: got %h want %h", sample_sat, exp_sat);
        end
    endtask

    task automatic test_negative_and_wrap();
        do_reset();
        voice_en = 4'b0001; k = '0; set_k(0, 22'h200000);
        run_pulse(lat, bcnt);
        checks++;
        if (sample_sat !== DW'(-rom_ref(0))) begin
            failures++; $display("FAIL negative_sample: got %h want %h", sample_sat, DW'(-rom_ref(0)));
        end
        do_reset();
        set_k(0, 22'h3FFFFF);
        run_pulse(lat, bcnt);
        checks++;
        if (sample_sat !== exp_sat) begin
            failures++; $display("FAIL preload_sample: got %h want %h", sample_sat, exp_sat);
        end
        set_k(0, 22'h000001);
        run_pulse(lat, bcnt);
        checks++;
        if (sample_sat !== DW'(rom_ref(0))) begin
            failures++; $display("FAIL wrap_sample: got %h want %h", sample_sat, DW'(rom_ref(0)));
        end
    endtask

    task automatic test_all_voices();
        do_reset();
        voice_en = 4'b1111;
        for (int i = 0; i < VOICES; i++) set_k(i, 22'h100000);
        run_pulse(lat, bcnt);
        checks++;
        if (sample_sat !== 16'h7FFF) begin
            failures++; $display("FAIL all_sat_clamp: got %h want 7fff", sample_sat);
        end
        checks++;
        if (sample_avg !== DW'(rom_ref(1023))) begin
            failures++; $display("FAIL all_avg: got %h want %h", sample_avg, DW'(rom_ref(1023)));
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        voice_en = 4'b0011; set_k(0, 22'h0A1234); set_k(1, 22'h051111);
        repeat (3) run_pulse(lat, bcnt);
        checks++;
        if (sample_sat !== exp_sat) begin
            failures++; $display("FAIL retrig_run: got %h want %h", sample_sat, exp_sat);
        end
        voice_en = 4'b0001; phase_clr = 4'b0001; set_k(0, 22'h000123);
        run_pulse(lat, bcnt);
        phase_clr = '0;
        checks++;
        if (sample_sat !== DW'(rom_ref(0))) begin
            failures++; $display("FAIL retrig_clear: got %h want %h", sample_sat, DW'(rom_ref(0)));
        end
        voice_en = 4'b0010; set_k(1, 0);
        run_pulse(lat, bcnt);
        checks++;
        if (sample_sat !== exp_sat) begin
            failures++; $display("FAIL retrig_hold_v1: got %h want %h", sample_sat, exp_sat);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < VOICES; i++) begin
                set_k(i, int'($urandom_range(0, 22'h3FFFFF)));
                voice_en[i]  = 1'($urandom_range(0, 1));
                phase_clr[i] = ($urandom_range(0, 3) == 0);
            end
            run_pulse(lat, bcnt);
            checks++;
            if (lat != 6) begin failures++; $display("FAIL rand_latency[%0d]: got %0d want 6", n, lat); end
            checks++;
            if (sample_sat !== exp_sat) begin
                failures++; $display("FAIL rand_sat[%0d]: got %h want %h", n, sample_sat, exp_sat);
            end
            checks++;
            if (sample_avg !== exp_avg) begin
                failures++; $display("FAIL rand_avg[%0d]: got %h want %h", n, sample_avg, exp_avg);
            end
        end
        phase_clr = '0;
    endtask

    task automatic test_back_to_back();
        voice_en = 4'b0101; set_k(0, 22'h012345); set_k(2, 22'h2ABCDE);
        run_pulse(lat, bcnt);
        run_pulse(lat, bcnt);
        checks++;
        if (lat != 6) begin failures++; $display("FAIL b2b_latency: got %0d want 6", lat); end
        checks++;
        if (sample_sat !== exp_sat) begin
            failures++; $display("FAIL b2b_sample: got %h want %h", sample_sat, exp_sat);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        voice_en = 4'b0001; phase_clr = '0; set_k(0, 22'h0C0F00);
        checks++;
        if (ovr_sat !== 1'b0) begin failures++; $display("FAIL overrun_clear: got %b want 0", ovr_sat); end
        ref_phase[0] = (ref_phase[0] + 22'h0C0F00) % (1 << 22);
        sampling_pulse = 1'b1;
        @(posedge clk); #1;
        sampling_pulse = 1'b0;
        @(posedge clk); #1;
        sampling_pulse = 1'b1;
        @(posedge clk); #1;
        sampling_pulse = 1'b0;
        rcnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (rdy_sat) rcnt++;
            @(posedge clk); #1;
        end
        exp_sat = DW'(model_mix(0));
        checks++;
        if (rcnt != 1) begin failures++; $display("FAIL overrun_strobes: got %0d want 1", rcnt); end
        checks++;
        if (ovr_sat !== 1'b1 || ovr_avg !== 1'b1) begin
            failures++; $display("FAIL overrun_flag: got %b%b want 11", ovr_sat, ovr_avg);
        end
        checks++;
        if (sample_sat !== exp_sat) begin
            failures++; $display("FAIL overrun_phase_once: got %h want %h", sample_sat, exp_sat);
        end
        run_pulse(lat, bcnt);
        checks++;
        if (ovr_sat !== 1'b1) begin failures++; $display("FAIL overrun_sticky: got %b want 1", ovr_sat); end
        checks++;
        if (sample_sat !== exp_sat) begin
            failures++; $display("FAIL overrun_next_sample: got %h want %h", sample_sat, exp_sat);
        end
    endtask

    initial begin
        test_reset();
        test_single_voice();
        test_negative_and_wrap();
        test_all_voices();
        test_retrigger();
        test_random();
        test_back_to_back();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
